// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: moves a WIDTH-bit operand one bit position per clock
// under a START/BUSY/DONE handshake, producing a registered result and carry.
module seq_shifter #(
    parameter int WIDTH      = 8,
    parameter int COUNT_W    = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic               CLK,
    input  logic               RESET_bar,
    input  logic               START,
    input  logic [2:0]         OP_SEL,
    input  logic [COUNT_W-1:0] COUNT,
    input  logic [WIDTH-1:0]   VALUE_IN,
    input  logic               CARRY_IN,
    output logic               BUSY,
    output logic               DONE,
    output logic [WIDTH-1:0]   VALUE_OUT,
    output logic               CARRY_OUT
);

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_PASS = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROLC = 3'b101;
    localparam logic [2:0] OP_RORC = 3'b110;
    localparam logic [2:0] OP_ROL  = 3'b111;

    // The rise/fall delays only shape the TTL timing model; the synthesised logic is zero-delay.
    if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   acc, acc_nx;
    logic               carry, carry_nx;
    logic [COUNT_W-1:0] rem, rem_nx;
    logic [2:0]         op, op_nx;
    logic [WIDTH-1:0]   value_nx;
    logic               carry_out_nx;
    logic [WIDTH:0]     stepped;

    // Returns {carry, value} after a single one-bit step of the selected operation.
    function automatic logic [WIDTH:0] step(input logic [2:0] sel,
                                            input logic [WIDTH-1:0] a,
                                            input logic c);
        logic [WIDTH:0] r;
        case (sel)
            OP_SHL:  r = {a[WIDTH-1], a[WIDTH-2:0], 1'b0};
            OP_SHR:  r = {a[0], 1'b0, a[WIDTH-1:1]};
            OP_ASR:  r = {a[0], a[WIDTH-1], a[WIDTH-1:1]};
            OP_ROLC: r = {a[WIDTH-1], a[WIDTH-2:0], c};
            OP_RORC: r = {a[0], c, a[WIDTH-1:1]};
            OP_ROL:  r = {a[WIDTH-1], a[WIDTH-2:0], a[WIDTH-1]};
            default: r = {c, a};
        endcase
        return r;
    endfunction

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        carry_nx     = carry;
        rem_nx       = rem;
        op_nx        = op;
        value_nx     = VALUE_OUT;
        carry_out_nx = CARRY_OUT;
        stepped      = step(op, acc, carry);

        case (state)
            S_SHIFT: begin
                {carry_nx, acc_nx} = stepped;
                rem_nx             = rem - 1'b1;
                if (rem == COUNT_W'(1)) begin
                    value_nx     = stepped[WIDTH-1:0];
                    carry_out_nx = stepped[WIDTH];
                    state_nx     = S_DONE;
                end
            end
            default: begin
                state_nx = S_IDLE;
                if (START) begin
                    acc_nx   = VALUE_IN;
                    carry_nx = CARRY_IN;
                    rem_nx   = COUNT;
                    op_nx    = OP_SEL;
                    // Zero, pass and zero-count ops complete on the accept edge itself.
                    if (OP_SEL == OP_ZERO) begin
                        value_nx     = '0;
                        carry_out_nx = 1'b0;
                        state_nx     = S_DONE;
                    end else if (OP_SEL == OP_PASS) begin
                        value_nx     = VALUE_IN;
                        carry_out_nx = 1'b0;
                        state_nx     = S_DONE;
                    end else if (COUNT == '0) begin
                        value_nx     = VALUE_IN;
                        carry_out_nx = CARRY_IN;
                        state_nx     = S_DONE;
                    end else begin
                        state_nx = S_SHIFT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_bar) begin
        if (!RESET_bar) begin
            state     <= S_IDLE;
            VALUE_OUT <= '0;
            CARRY_OUT <= 1'b0;
        end else begin
            state     <= state_nx;
            VALUE_OUT <= value_nx;
            CARRY_OUT <= carry_out_nx;
        end
    end

    // Working registers are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge CLK) begin
        acc   <= acc_nx;
        carry <= carry_nx;
        rem   <= rem_nx;
        op    <= op_nx;
    end

    assign BUSY = (state == S_SHIFT);
    assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed plus randomized bench for seq_shifter against a closed-form shift/rotate model.
module tb_seq_shifter;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          CLK;
    logic          RESET_bar;
    logic          START;
    logic [2:0]    OP_SEL;
    logic [CW-1:0] COUNT;
    logic [W-1:0]  VALUE_IN;
    logic          CARRY_IN;
    logic          BUSY;
    logic          DONE;
    logic [W-1:0]  VALUE_OUT;
    logic          CARRY_OUT;

    int checks = 0;
    int errors = 0;

    seq_shifter #(.WIDTH(W), .COUNT_W(CW), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .CLK(CLK), .RESET_bar(RESET_bar), .START(START), .OP_SEL(OP_SEL),
        .COUNT(COUNT), .VALUE_IN(VALUE_IN), .CARRY_IN(CARRY_IN), .BUSY(BUSY),
        .DONE(DONE), .VALUE_OUT(VALUE_OUT), .CARRY_OUT(CARRY_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        checks++;
        assert (!(BUSY && DONE)) else begin
            errors++;
            $error("FAIL busy_done_overlap: busy=%0b done=%0b required not both high", BUSY, DONE);
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {carry, value} after n steps, computed as whole-word arithmetic.
    function automatic logic [W:0] model(input logic [2:0] op, input int n,
                                         input logic [W-1:0] v, input logic cin);
        longint mask  = (64'd1 << W) - 1;
        longint mask9 = (64'd1 << (W + 1)) - 1;
        longint x, y, sv, r;
        longint c;
        int k;
        if (op == 3'b000) return '0;
        if (op == 3'b001) return {1'b0, v};
        if (n == 0) return {cin, v};
        r = 0;
        c = 0;
        x = (longint'(cin) << W) | longint'(v);
        case (op)
            3'b010: begin
                r = (longint'(v) << n) & mask;
                c = (n <= W) ? ((longint'(v) >> (W - n)) & 1) : 0;
            end
            3'b011: begin
                r = longint'(v) >> n;
                c = (n <= W) ? ((longint'(v) >> (n - 1)) & 1) : 0;
            end
            3'b100: begin
                sv = longint'(v);
                if (v[W-1]) sv = sv - (64'd1 << W);
                r = (sv >>> n) & mask;
                c = (sv >>> (n - 1)) & 1;
            end
            3'b101, 3'b110: begin
                k = n % (W + 1);
                if (k == 0) y = x;
                else if (op == 3'b101) y = ((x << k) | (x >> (W + 1 - k))) & mask9;
                else y = ((x >> k) | (x << (W + 1 - k))) & mask9;
                r = y & mask;
                c = (y >> W) & 1;
            end
            default: begin
                k = n % W;
                r = ((longint'(v) << k) | (longint'(v) >> (W - k))) & mask;
                c = r & 1;
            end
        endcase
        return {c[0], r[W-1:0]};
    endfunction

    task automatic launch(input logic [2:0] op, input int n, input logic [W-1:0] v, input logic cin);
        @(negedge CLK);
        START    = 1'b1;
        OP_SEL   = op;
        COUNT    = CW'(n);
        VALUE_IN = v;
        CARRY_IN = cin;
        @(posedge CLK);
        #1;
        START    = 1'b0;
        OP_SEL   = 3'($urandom);
        COUNT    = CW'($urandom);
        VALUE_IN = W'($urandom);
        CARRY_IN = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        @(negedge CLK);
        while (!DONE && lat < 64) begin
            if (BUSY) busy_n++;
            @(negedge CLK);
            lat++;
        end
        chk("done_timeout", longint'(DONE), 1);
    endtask

    task automatic run_check(input string tag, input logic [2:0] op, input int n,
                             input logic [W-1:0] v, input logic cin);
        logic [W:0] exp;
        int lat, busy_n, steps;
        exp = model(op, n, v, cin);
        steps = (op == 3'b000 || op == 3'b001) ? 0 : n;
        launch(op, n, v, cin);
        wait_done(lat, busy_n);
        chk({tag, "_latency"}, lat, steps);
        chk({tag, "_busy_cycles"}, busy_n, steps);
        chk({tag, "_value"}, VALUE_OUT, exp[W-1:0]);
        chk({tag, "_carry"}, CARRY_OUT, exp[W]);
        @(negedge CLK);
        chk({tag, "_done_pulse"}, DONE, 0);
        chk({tag, "_hold"}, {CARRY_OUT, VALUE_OUT}, exp);
    endtask

    initial begin
        int lat, busy_n;
        RESET_bar = 1'b0;
        START     = 1'b0;
        OP_SEL    = '0;
        COUNT     = '0;
        VALUE_IN  = '0;
        CARRY_IN  = 1'b0;
        #1;
        chk("reset_value", VALUE_OUT, 0);
        chk("reset_carry", CARRY_OUT, 0);
        chk("reset_busy", BUSY, 0);
        chk("reset_done", DONE, 0);
        repeat (3) @(negedge CLK);
        RESET_bar = 1'b1;

        run_check("shl_b5_3", 3'b010, 3, 8'hB5, 1'b0);
        chk("shl_b5_3_value_const", VALUE_OUT, 8'hA8);
        run_check("asr_90_2", 3'b100, 2, 8'h90, 1'b0);
        chk("asr_90_2_value_const", VALUE_OUT, 8'hE4);
        run_check("shr_90_8", 3'b011, 8, 8'h90, 1'b0);
        chk("shr_90_8_carry_const", CARRY_OUT, 1);
        run_check("rorc_01_1", 3'b110, 1, 8'h01, 1'b0);
        chk("rorc_01_1_carry_const", CARRY_OUT, 1);
        run_check("rorc_01_9", 3'b110, 9, 8'h01, 1'b0);
        chk("rorc_01_9_value_const", VALUE_OUT, 8'h01);
        run_check("rol_b5_8", 3'b111, 8, 8'hB5, 1'b0);
        chk("rol_b5_8_carry_const", CARRY_OUT, 1);
        run_check("shl_42_0", 3'b010, 0, 8'h42, 1'b1);
        run_check("shl_over_15", 3'b010, 15, 8'hFF, 1'b0);

        // A START during SHIFT must be ignored; a START in the DONE cycle is accepted.
        launch(3'b010, 4, 8'h01, 1'b0);
        @(posedge CLK);
        #1;
        START  = 1'b1;
        OP_SEL = 3'b000;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(lat, busy_n);
        chk("ignore_start_latency", lat, 2);
        chk("ignore_start_value", VALUE_OUT, 8'h10);
        chk("ignore_start_carry", CARRY_OUT, 0);
        START    = 1'b1;
        OP_SEL   = 3'b001;
        VALUE_IN = 8'h3C;
        CARRY_IN = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        @(negedge CLK);
        chk("b2b_done", DONE, 1);
        chk("b2b_busy", BUSY, 0);
        chk("b2b_value", VALUE_OUT, 8'h3C);
        chk("b2b_carry", CARRY_OUT, 0);

        // Reset in the middle of a rotate aborts it with no DONE.
        launch(3'b101, 6, 8'hC3, 1'b1);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RESET_bar = 1'b0;
        #1;
        chk("abort_value", VALUE_OUT, 0);
        chk("abort_carry", CARRY_OUT, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_done", DONE, 0);
        @(negedge CLK);
        RESET_bar = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            chk("abort_no_done", DONE, 0);
        end
        run_check("zero_after_reset", 3'b000, 5, 8'hFF, 1'b1);

        for (int i = 0; i < 40; i++) begin
            run_check("random", 3'($urandom), int'($urandom_range(0, 15)),
                      W'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
